bin_to_onehot_pipe: RTL and testbench

Registered binary-index to one-hot decoder with a valid/ready handshake on both sides. It is the inverse of the one-hot-to-binary encoder and is used to turn arbiter and FIFO pointers back into select or grant vectors. A two-entry skid buffer gives full throughput with a registered in_ready_o. Out-of-range indices are flagged and counted.

---
 rtl/bin_to_onehot_pkg.sv | 11 +
 rtl/bin_to_onehot_dec.sv | 12 +
 rtl/bin_to_onehot_pipe.sv | 77 +++++++
 tb/tb_bin_to_onehot_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_onehot_pkg.sv
// bin_to_onehot_pkg: shared width helper and handshake state encoding
package bin_to_onehot_pkg;
    function automatic int bin_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } state_t;
endpackage

// File: rtl/bin_to_onehot_dec.sv
// bin_to_onehot_dec: combinational index decode with out-of-range flag
module bin_to_onehot_dec #(
    parameter int ONEHOT_WIDTH = 8,
    parameter int BIN_WIDTH = 3
) (
    input  logic [BIN_WIDTH-1:0]    bin,
    output logic [ONEHOT_WIDTH-1:0] onehot,
    output logic                    oor
);
    assign oor = {1'b0, bin} >= (BIN_WIDTH+1)'(ONEHOT_WIDTH);
    assign onehot = oor ? '0 : ONEHOT_WIDTH'(1) << bin;
endmodule

// File: rtl/bin_to_onehot_pipe.sv
// bin_to_onehot_pipe: registered binary-to-one-hot decoder with skid buffer and error counter
module bin_to_onehot_pipe
    import bin_to_onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH = 8,
    parameter int BIN_WIDTH = bin_width(ONEHOT_WIDTH),
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [BIN_WIDTH-1:0]     bin_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    output logic [ONEHOT_WIDTH-1:0]  onehot_o,
    output logic                     oor_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
    input  logic                     err_clr_i
);
    typedef struct packed {
        logic [ONEHOT_WIDTH-1:0] onehot;
        logic                    oor;
    } entry_t;
    state_t state, state_nxt;
    entry_t dec, main_q, skid_q;
    logic [ONEHOT_WIDTH-1:0] dec_onehot;
    logic dec_oor, in_fire, out_fire;
    bin_to_onehot_dec #(
        .ONEHOT_WIDTH(ONEHOT_WIDTH),
        .BIN_WIDTH(BIN_WIDTH)
    ) u_dec (
        .bin(bin_i),
        .onehot(dec_onehot),
        .oor(dec_oor)
    );
    assign dec = '{onehot: dec_onehot, oor: dec_oor};
    // state bits are {main_valid, skid_valid}, so ready is a direct flop output
    assign in_ready_o = ~state[0];
    assign out_valid_o = state[1];
    assign onehot_o = main_q.onehot;
    assign oor_o = main_q.oor;
    assign in_fire = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   state_nxt = in_fire ? ONE : EMPTY;
            ONE:     state_nxt = (in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE;
            TWO:     state_nxt = out_fire ? ONE : TWO;
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == TWO && out_fire)
                main_q <= skid_q;
            else if (in_fire && (state == EMPTY || out_fire))
                main_q <= dec;
            if (in_fire && state == ONE && !out_fire)
                skid_q <= dec;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            err_cnt_o <= '0;
        else if (err_clr_i)
            err_cnt_o <= '0;
        else if (in_fire && dec_oor && err_cnt_o != '1)
            err_cnt_o <= err_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_bin_to_onehot_pipe.sv
// tb_bin_to_onehot_pipe: directed and randomized checks against a queue-based reference model
module tb_bin_to_onehot_pipe;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic [2:0] b8 = 0;
    logic v8 = 0, or8 = 0, clr8 = 0;
    logic r8, oor8, ov8;
    logic [7:0] oh8, ec8;

    logic [2:0] b6 = 0;
    logic v6 = 0, or6 = 0, clr6 = 0;
    logic r6, oor6, ov6;
    logic [5:0] oh6;
    logic [1:0] ec6;

    int pass_cnt = 0;
    int total_cnt = 0;

    bin_to_onehot_pipe #(.ONEHOT_WIDTH(8), .ERR_CNT_WIDTH(8)) u8 (
        .clk_i(clk), .rst_ni(rst_n), .bin_i(b8), .in_valid_i(v8), .in_ready_o(r8),
        .onehot_o(oh8), .oor_o(oor8), .out_valid_o(ov8), .out_ready_i(or8),
        .err_cnt_o(ec8), .err_clr_i(clr8)
    );

    bin_to_onehot_pipe #(.ONEHOT_WIDTH(6), .ERR_CNT_WIDTH(2)) u6 (
        .clk_i(clk), .rst_ni(rst_n), .bin_i(b6), .in_valid_i(v6), .in_ready_o(r6),
        .onehot_o(oh6), .oor_o(oor6), .out_valid_o(ov6), .out_ready_i(or6),
        .err_cnt_o(ec6), .err_clr_i(clr6)
    );

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({ov8, oh8, oor8, ec8, r8} !== {1'b0, 8'h00, 1'b0, 8'h00, 1'b1})
            $display("FAIL reset_held u8 got %b want %b", {ov8, oh8, oor8, ec8, r8}, {1'b0, 8'h00, 1'b0, 8'h00, 1'b1});
        else pass_cnt++;
        total_cnt++;
        if ({ov6, oh6, oor6, ec6, r6} !== {1'b0, 6'h00, 1'b0, 2'd0, 1'b1})
            $display("FAIL reset_held u6 got %b want %b", {ov6, oh6, oor6, ec6, r6}, {1'b0, 6'h00, 1'b0, 2'd0, 1'b1});
        else pass_cnt++;
        rst_n = 1;
        @(negedge clk);
        total_cnt++;
        if ({ov8, r8} !== 2'b01)
            $display("FAIL reset_release got valid/ready %b want 01", {ov8, r8});
        else pass_cnt++;
    endtask

    task automatic test_single();
        or8 = 0; b8 = 3; v8 = 1;
        @(negedge clk);
        v8 = 0;
        total_cnt++;
        if ({ov8, oh8, oor8, r8} !== {1'b1, 8'b0000_1000, 1'b0, 1'b1})
            $display("FAIL single got %b want %b", {ov8, oh8, oor8, r8}, {1'b1, 8'b0000_1000, 1'b0, 1'b1});
        else pass_cnt++;
        or8 = 1;
        @(negedge clk);
        or8 = 0;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL single_drain got valid %b want 0", ov8);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        or8 = 1;
        for (int i = 0; i < 8; i++) begin
            b8 = 3'(i); v8 = 1;
            total_cnt++;
            if (r8 !== 1'b1) $display("FAIL stream_ready idx %0d got %b want 1", i, r8);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({ov8, oh8, oor8} !== {1'b1, 8'(1 << i), 1'b0})
                $display("FAIL stream_word idx %0d got %b want %b", i, {ov8, oh8, oor8}, {1'b1, 8'(1 << i), 1'b0});
            else pass_cnt++;
        end
        v8 = 0;
        @(negedge clk);
        or8 = 0;
        total_cnt++;
        if (ov8 !== 1'b0) $display("FAIL stream_end got valid %b want 0", ov8);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        or8 = 0; b8 = 5; v8 = 1;
        @(negedge clk);
        b8 = 6;
        @(negedge clk);
        v8 = 0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if ({ov8, oh8, r8} !== {1'b1, 8'h20, 1'b0})
                $display("FAIL bp_hold cyc %0d got %b want %b", i, {ov8, oh8, r8}, {1'b1, 8'h20, 1'b0});
            else pass_cnt++;
            @(negedge clk);
        end
        or8 = 1;
        @(negedge clk);
        total_cnt++;
        if ({ov8, oh8, r8} !== {1'b1, 8'h40, 1'b1})
            $display("FAIL bp_second got %b want %b", {ov8, oh8, r8}, {1'b1, 8'h40, 1'b1});
        else pass_cnt++;
        @(negedge clk);
        or8 = 0;
        total_cnt++;
        if ({ov8, r8} !== 2'b01) $display("FAIL bp_drain got %b want 01", {ov8, r8});
        else pass_cnt++;
    endtask

    task automatic test_oor();
        or6 = 1; v6 = 1;
        for (int i = 6; i < 8; i++) begin
            b6 = 3'(i);
            @(negedge clk);
            total_cnt++;
            if ({ov6, oh6, oor6} !== {1'b1, 6'h00, 1'b1})
                $display("FAIL oor_word bin %0d got %b want %b", i, {ov6, oh6, oor6}, {1'b1, 6'h00, 1'b1});
            else pass_cnt++;
        end
        v6 = 0;
        @(negedge clk);
        total_cnt++;
        if (ec6 !== 2'd2) $display("FAIL oor_count got %0d want 2", ec6);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        or6 = 1; v6 = 1;
        for (int i = 0; i < 5; i++) begin
            b6 = (i % 2) ? 3'd7 : 3'd6;
            @(negedge clk);
        end
        b6 = 2;
        @(negedge clk);
        v6 = 0;
        total_cnt++;
        if ({ec6, oh6, oor6} !== {2'd3, 6'h04, 1'b0})
            $display("FAIL sat_count got %b want %b", {ec6, oh6, oor6}, {2'd3, 6'h04, 1'b0});
        else pass_cnt++;
        clr6 = 1; b6 = 7; v6 = 1;
        @(negedge clk);
        clr6 = 0; v6 = 0;
        total_cnt++;
        if ({ec6, ov6, oor6} !== {2'd0, 1'b1, 1'b1})
            $display("FAIL clr_priority got %b want %b", {ec6, ov6, oor6}, {2'd0, 1'b1, 1'b1});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (ec6 !== 2'd0) $display("FAIL clr_hold got %0d want 0", ec6);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        or8 = 0; or6 = 0; b8 = 1; v8 = 1; b6 = 7; v6 = 1;
        @(negedge clk);
        b8 = 2; v6 = 0;
        @(negedge clk);
        v8 = 0;
        total_cnt++;
        if ({r8, ec6} !== {1'b0, 2'd1}) $display("FAIL mr_setup got %b want %b", {r8, ec6}, {1'b0, 2'd1});
        else pass_cnt++;
        rst_n = 0;
        #1;
        total_cnt++;
        if ({ov8, oh8, ec8, r8, ov6, ec6} !== {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0})
            $display("FAIL mr_async got %b want %b", {ov8, oh8, ec8, r8, ov6, ec6}, {1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1; or8 = 1; or6 = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({ov8, ov6, r8} !== 3'b001) $display("FAIL mr_stale cyc %0d got %b want 001", i, {ov8, ov6, r8});
            else pass_cnt++;
        end
        or8 = 0;
    endtask

    task automatic test_random();
        logic [6:0] q[$];
        logic [6:0] ent;
        int cnt = 0;
        int pb = 0;
        bit pend = 0;
        bit in_fire, out_fire;
        clr6 = 1; v6 = 0; or6 = 1;
        @(negedge clk);
        clr6 = 0;
        for (int c = 0; c < 600; c++) begin
            total_cnt++;
            if ({ov6, r6} !== {q.size() > 0, q.size() < 2})
                $display("FAIL rnd_hs cyc %0d got %b want %b", c, {ov6, r6}, {q.size() > 0, q.size() < 2});
            else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++;
                if ({oh6, oor6} !== q[0]) $display("FAIL rnd_word cyc %0d got %b want %b", c, {oh6, oor6}, q[0]);
                else pass_cnt++;
            end
            total_cnt++;
            if (ec6 !== 2'(cnt)) $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, ec6, cnt);
            else pass_cnt++;
            if (!pend) begin
                pend = $urandom_range(0, 1) == 1;
                pb = $urandom_range(0, 7);
            end
            v6 = pend;
            b6 = 3'(pb);
            or6 = $urandom_range(0, 2) != 0;
            clr6 = $urandom_range(0, 15) == 0;
            in_fire = pend && q.size() < 2;
            out_fire = or6 && q.size() > 0;
            ent = (pb < 6) ? {6'(1 << pb), 1'b0} : {6'h00, 1'b1};
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                q.push_back(ent);
                pend = 0;
            end
            if (clr6) cnt = 0;
            else if (in_fire && pb >= 6 && cnt < 3) cnt++;
            @(negedge clk);
        end
        v6 = 0; clr6 = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_back_to_back();
        test_oor();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
